// File: rtl/z180_bus_master_if.sv
// z180_bus_master_if: Z8S180 shared-bus pins between the bus master and the board top level.
interface z180_bus_master_if;
  logic        busreq_n;
  logic        busack_n;
  logic        bus_oe;
  logic [19:0] a_out;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  modport master (
    output busreq_n, bus_oe, a_out, d_out, d_oe, mreq_n, rd_n, wr_n,
    input  busack_n, d_in
  );
  modport slave (
    input  busreq_n, bus_oe, a_out, d_out, d_oe, mreq_n, rd_n, wr_n,
    output busack_n, d_in
  );
endinterface

// File: rtl/z180_bus_master.sv
// z180_bus_master: takes the Z8S180 bus via /BUSREQ and copies a block between SRAM and a byte stream.
// Optional BUS_MASTER_TIMEOUT_EN: give up with error=1 when /BUSACK never arrives.
module z180_bus_master #(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 3,
  parameter int HOLD_CYCLES    = 1,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [19:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  z180_bus_master_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, ZERO, REQ, TURN, FETCH, SETUP, STROBE, HOLD, DELIVER, NEXT, RELEASE
  } state_t;
  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  state_t           state, state_d;
  logic [1:0]       ack_sync;
  logic             ack_s;
  logic [15:0]      cnt;
  logic [LEN_W-1:0] rem;
  logic             dir_q;
  logic             accept;
  logic             timeout;
  logic             own_d;
  logic             req_d;
  assign ack_s  = ack_sync[1];
  assign accept = state == IDLE && start && !abort;
  assign busy   = state != IDLE;
  assign own_d  = state_d inside {TURN, FETCH, SETUP, STROBE, HOLD, DELIVER, NEXT};
  assign req_d  = own_d || state_d == REQ;
`ifdef BUS_MASTER_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) to_cnt <= '0;
    else to_cnt <= state == REQ ? to_cnt + 32'd1 : '0;
  assign timeout = state == REQ && !ack_s && to_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? (length == '0 ? ZERO : REQ) : IDLE;
      ZERO:    state_d = IDLE;
      REQ:     state_d = (abort || timeout) ? RELEASE : ack_s ? TURN : REQ;
      TURN:    state_d = dir_q ? SETUP : FETCH;
      FETCH:   state_d = s_valid ? SETUP : abort ? RELEASE : FETCH;
      SETUP:   state_d = cnt == SETUP_LAST ? STROBE : SETUP;
      STROBE:  state_d = cnt == STROBE_LAST ? HOLD : STROBE;
      HOLD:    state_d = cnt == HOLD_LAST ? (dir_q ? DELIVER : NEXT) : HOLD;
      DELIVER: state_d = m_ready ? NEXT : DELIVER;
      NEXT:    state_d = (rem == LEN_W'(1) || abort) ? RELEASE : dir_q ? SETUP : FETCH;
      RELEASE: state_d = ack_s ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Pins are registered from the next state so they change cleanly on the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ack_sync     <= '0;
      cnt          <= '0;
      rem          <= '0;
      dir_q        <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      bus.busreq_n <= 1'b1;
      bus.bus_oe   <= 1'b0;
      bus.a_out    <= '0;
      bus.d_out    <= '0;
      bus.d_oe     <= 1'b0;
      bus.mreq_n   <= 1'b1;
      bus.rd_n     <= 1'b1;
      bus.wr_n     <= 1'b1;
    end else begin
      state        <= state_d;
      ack_sync     <= {ack_sync[0], ~bus.busack_n};
      cnt          <= state_d == state ? cnt + 16'd1 : '0;
      done         <= state_d == IDLE && (state == ZERO || state == RELEASE);
      s_ready      <= state_d == FETCH && !dir_q;
      m_valid      <= state_d == DELIVER;
      bus.busreq_n <= !req_d;
      bus.bus_oe   <= own_d;
      bus.d_oe     <= !dir_q && state_d inside {SETUP, STROBE, HOLD};
      bus.mreq_n   <= state_d != STROBE;
      bus.wr_n     <= !(state_d == STROBE && !dir_q);
      bus.rd_n     <= !(state_d == STROBE && dir_q);
      if (accept) begin
        dir_q     <= dir;
        bus.a_out <= base_addr;
        rem       <= length;
        error     <= 1'b0;
      end
      if (timeout) error <= 1'b1;
      if (state == FETCH && s_valid) bus.d_out <= s_data;
      if (state == STROBE && dir_q && cnt == STROBE_LAST) m_data <= bus.d_in;
      if (state == NEXT) begin
        bus.a_out <= bus.a_out + 20'd1;
        rem       <= rem - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_z180_bus_master.sv
// tb_z180_bus_master: directed checks of the bus master against an SRAM, CPU-ack and stream model.
module tb_z180_bus_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir = 1'b0;
  logic [19:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, error, s_ready, m_valid;
  logic [7:0]  m_data;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        m_ready = 1'b0;
  logic        mr_tog = 1'b0;
  logic        ack_en = 1'b1;
  logic        s_hs = 1'b0;
  logic [7:0]  sram [1<<20];
  logic [7:0]  s_q [64];
  logic [7:0]  got [$];
  int nchk = 0, npass = 0;
  int nwr = 0, bad_w = 0, proto = 0, ndone = 0, nreq = 0, wr_run = 0;
  int rq_cnt = 0, rel_cnt = 0, s_idx = 0, s_n = 0;
  int d0, w0, q0, g0, s0;

  z180_bus_master_if bus();

  z180_bus_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .dir(dir),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done), .error(error),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .bus(bus)
  );

  always #5 clk = ~clk;

  // CPU: grants the bus 5 clocks after /BUSREQ, withdraws /BUSACK 2 clocks after release.
  always @(negedge clk) begin
    if (!bus.busreq_n) begin
      rel_cnt = 0;
      rq_cnt++;
      if (rq_cnt >= 5 && ack_en) bus.busack_n = 1'b0;
    end else begin
      rq_cnt = 0;
      rel_cnt++;
      if (rel_cnt >= 2) bus.busack_n = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) wr_run = 0;
    else begin
      if (!bus.wr_n) begin
        wr_run++;
        sram[bus.a_out] = bus.d_out;
      end else if (wr_run != 0) begin
        nwr++;
        if (wr_run != 3) bad_w++;
        wr_run = 0;
      end
      if ((!bus.mreq_n || !bus.rd_n || !bus.wr_n) && !bus.bus_oe) proto++;
      if ((!bus.rd_n || !bus.wr_n) && bus.mreq_n) proto++;
      if (!bus.rd_n && !bus.wr_n) proto++;
      if (bus.bus_oe && bus.busack_n) proto++;
      if (!bus.wr_n && !bus.d_oe) proto++;
    end
    if (done) ndone++;
    if (!bus.busreq_n) nreq++;
    bus.d_in = !bus.rd_n ? sram[bus.a_out] : 8'h00;
  end

  always @(negedge clk) begin
    if (s_hs) s_idx++;
    s_valid = s_idx < s_n;
    s_data  = s_valid ? s_q[s_idx[5:0]] : 8'h00;
    s_hs    = s_valid && s_ready;
  end

  always @(negedge clk) begin
    m_ready = mr_tog ? ~m_ready : 1'b1;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_s(input logic [7:0] v);
    s_q[s_n[5:0]] = v;
    s_n++;
  endtask

  task automatic go(input logic d, input logic [19:0] b, input logic [15:0] n);
    @(negedge clk);
    dir = d;
    base_addr = b;
    length = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d_ref, input int lim);
    for (int i = 0; i < lim && ndone == d_ref; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_busreq_n", bus.busreq_n, 1);
    chk("rst_strobes", {bus.mreq_n, bus.rd_n, bus.wr_n}, 3'b111);
    chk("rst_oe", {bus.bus_oe, bus.d_oe, s_ready, m_valid}, 4'b0000);
    chk("rst_a_out", bus.a_out, 0);
    chk("rst_data", {bus.d_out, m_data}, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    s_n = s_idx;
    push_s(8'h11); push_s(8'h22); push_s(8'h33); push_s(8'h44);
    d0 = ndone; w0 = nwr;
    go(1'b0, 20'h01000, 16'd4);
    wait_done(d0, 500);
    chk("wr_done", ndone - d0, 1);
    chk("wr_count", nwr - w0, 4);
    chk("wr_m0", sram[20'h01000], 8'h11);
    chk("wr_m1", sram[20'h01001], 8'h22);
    chk("wr_m2", sram[20'h01002], 8'h33);
    chk("wr_m3", sram[20'h01003], 8'h44);
    chk("wr_width", bad_w, 0);
    chk("wr_released", {bus.busreq_n, bus.bus_oe, busy}, 3'b100);

    s_n = s_idx;
    push_s(8'hA5); push_s(8'h5A); push_s(8'hC3);
    d0 = ndone;
    go(1'b0, 20'hFFFFE, 16'd3);
    wait_done(d0, 500);
    chk("wrap_wr_hi", sram[20'hFFFFF], 8'h5A);
    chk("wrap_wr_lo", sram[20'h00000], 8'hC3);

    mr_tog = 1'b1;
    g0 = got.size(); d0 = ndone;
    go(1'b1, 20'hFFFFE, 16'd3);
    wait_done(d0, 500);
    mr_tog = 1'b0;
    chk("rd_done", ndone - d0, 1);
    chk("rd_count", got.size() - g0, 3);
    if (got.size() - g0 == 3) begin
      chk("rd_b0", got[g0], 8'hA5);
      chk("rd_b1", got[g0+1], 8'h5A);
      chk("rd_b2", got[g0+2], 8'hC3);
    end

    q0 = nreq; d0 = ndone;
    go(1'b0, 20'h05000, 16'd0);
    chk("zero_busy", busy, 1);
    chk("zero_done_early", done, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy_drop", busy, 0);
    repeat (3) @(negedge clk);
    chk("zero_busreq", nreq - q0, 0);
    chk("zero_done_once", ndone - d0, 1);

    s_n = s_idx;
    for (int k = 1; k <= 8; k++) push_s(8'(k));
    s0 = s_idx; d0 = ndone; w0 = nwr;
    go(1'b0, 20'h02000, 16'd8);
    for (int i = 0; i < 500 && !(nwr == w0 + 1 && !bus.wr_n); i++) @(negedge clk);
    abort = 1'b1;
    chk("abort_in_strobe", bus.wr_n, 0);
    wait_done(d0, 500);
    abort = 1'b0;
    chk("abort_done", ndone - d0, 1);
    chk("abort_count", nwr - w0, 2);
    chk("abort_m0", sram[20'h02000], 8'h01);
    chk("abort_m1", sram[20'h02001], 8'h02);
    chk("abort_width", bad_w, 0);
    chk("abort_stream", s_idx - s0, 2);
    chk("abort_busreq_n", bus.busreq_n, 1);

    s_n = s_idx;
    push_s(8'h77); push_s(8'h88);
    d0 = ndone;
    go(1'b0, 20'h03000, 16'd2);
    for (int i = 0; i < 500 && bus.wr_n; i++) @(negedge clk);
    chk("rst_in_strobe", bus.wr_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_strobes", {bus.mreq_n, bus.wr_n}, 2'b11);
    chk("async_bus_oe", bus.bus_oe, 0);
    chk("async_busreq_n", bus.busreq_n, 1);
    chk("async_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", ndone - d0, 0);

    d0 = ndone;
    @(negedge clk);
    abort = 1'b1; start = 1'b1; length = 16'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("ignored_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("ignored_done", ndone - d0, 0);

    s_n = s_idx;
    push_s(8'h9C);
    d0 = ndone;
    go(1'b0, 20'h03000, 16'd1);
    wait_done(d0, 500);
    chk("recover_m", sram[20'h03000], 8'h9C);
    chk("recover_done", ndone - d0, 1);
    chk("no_error", error, 0);

`ifdef BUS_MASTER_TIMEOUT_EN
    ack_en = 1'b0;
    d0 = ndone;
    go(1'b0, 20'h04000, 16'd1);
    wait_done(d0, 5000);
    chk("timeout_error", error, 1);
    chk("timeout_done", ndone - d0, 1);
    ack_en = 1'b1;
    go(1'b0, 20'h04000, 16'd0);
    chk("timeout_clear", error, 0);
    repeat (3) @(negedge clk);
`endif

    chk("protocol", proto, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish before 800000");
    $fatal(1);
  end
endmodule
